key_debouncer: RTL and testbench
================================

# key_debouncer

Front-end conditioning stage for the board push-buttons and the mode switch. It synchronises the raw active-low KEY inputs and SW[0] to the system clock and debounces each channel independently. It emits clean active-high key levels, single-cycle press pulses and a debounced switch level. These outputs drive the button/command splitter directly, so that block only ever sees one event per physical press.

## Interface
Parameters:
- DB_CNT, 1000000: consecutive stable cycles required to accept a level change (20 ms at 50 MHz); legal range 2 to 2^CNT_W-1.
- REPEAT_DELAY, 25000000: cycles a key must be held before the first auto-repeat pulse (500 ms). Used only with AUTO_REPEAT_EN.
- REPEAT_PERIOD, 5000000: cycles between subsequent auto-repeat pulses (100 ms). Used only with AUTO_REPEAT_EN.
- CNT_W, 25: width of every per-channel counter; must hold the largest of the three counts above.

Ports:
- CLOCK_50 in 1: system clock; all logic on the rising edge.
- RESET_N in 1: synchronous, active-low reset.
- KEY_N in 4: raw board keys, asynchronous, active-low (0 = pressed).
- SW_RAW in 1: raw SW[0], asynchronous, active-high.
- KEY_LEVEL out 4: debounced key state, active-high (1 = held).
- KEY_PULSE out 4: one-cycle high pulse per accepted press (and per repeat, if enabled).
- SW_OUT out 1: debounced SW[0] level.

## Operation
- Input stage: two-flop synchroniser on each of the 5 inputs. KEY_N is inverted after the second flop, so all internal logic is active-high.
- Each of the 5 channels has its own FSM and counter. There is no shared state, so any combination of channels may change in the same cycle.
- FSM states:
  - STABLE_LO: level 0. A synchronised 1 clears the counter and moves to WAIT_HI.
  - WAIT_HI: the counter increments each cycle the sample is 1. A sample of 0 returns to STABLE_LO and clears the counter (bounce rejected). When the counter reaches DB_CNT-1 with the sample still 1, the FSM moves to STABLE_HI.
  - STABLE_HI: level 1. A synchronised 0 clears the counter and moves to WAIT_LO.
  - WAIT_LO: mirror of WAIT_HI. It returns to STABLE_HI on a 1 and moves to STABLE_LO after DB_CNT consecutive 0 samples.
- The KEY_LEVEL or SW_OUT bit is registered from the FSM and equals 1 in STABLE_HI and WAIT_LO.
- KEY_PULSE[i] is asserted for exactly one cycle on the WAIT_HI→STABLE_HI transition only. There is no pulse on release, and the switch channel has no pulse.
- A glitch shorter than DB_CNT cycles never changes any output.
- Counters saturate and never wrap. Counter compares are at CNT_W bits, unsigned.

## Timing
- Reset (RESET_N low at a clock edge):
  - all FSMs go to STABLE_LO and all counters to 0;
  - synchroniser flops load the released value (KEY_N path 1, SW path 0);
  - KEY_LEVEL = 0, KEY_PULSE = 0, SW_OUT = 0.
- Reset mid-debounce discards the pending count; no pulse is emitted. A key still held when reset deasserts is re-debounced from zero and then pulses normally.
- Press latency: 2 synchroniser cycles + DB_CNT stable cycles. KEY_LEVEL rises and KEY_PULSE fires in the same cycle, i.e. DB_CNT+2 cycles after the first clean raw edge. Release latency is identical, with no pulse.
- The pulse is one cycle wide regardless of how long the key is held (without auto-repeat).
- Simultaneous presses on several keys yield simultaneous pulses; none are dropped or serialised.

## Configuration
- Macro: KEY_DEBOUNCER_AUTO_REPEAT_EN.
- Defined:
  - In STABLE_HI, each key channel runs a repeat counter cleared on entry.
  - After REPEAT_DELAY cycles in STABLE_HI, KEY_PULSE[i] fires once; it then fires again every REPEAT_PERIOD cycles while the FSM stays in STABLE_HI.
  - WAIT_LO freezes the repeat counter. A bounce back to STABLE_HI resumes the count; an accepted release clears it.
  - A repeat pulse never coincides with the press pulse.
- Undefined: no repeat logic is synthesised, REPEAT_* parameters are ignored, and there is exactly one pulse per press.

## Test plan
Simulate with DB_CNT=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Reset: hold RESET_N=0 with KEY_N=4'b0000 for 5 cycles → all outputs 0. Release reset → KEY_LEVEL=4'b1111 and a single KEY_PULSE=4'b1111 exactly 6 cycles later.
- Clean press: KEY_N[2] falls to 0 and holds → KEY_PULSE=4'b0100 for one cycle, 6 cycles after the edge; KEY_LEVEL[2] stays 1. Release → KEY_LEVEL[2]=0 6 cycles later, with no pulse.
- Bounce: KEY_N[0] toggles 0/1 every 2 cycles for 20 cycles, then settles at 1 → KEY_LEVEL and KEY_PULSE stay 0 throughout.
- Simultaneous: KEY_N[1] and KEY_N[3] fall in the same cycle while SW_RAW rises → KEY_PULSE=4'b1010 and SW_OUT=1 in the same cycle, 6 cycles later.
- Reset mid-debounce: press KEY_N[1], assert RESET_N=0 at cycle 3 for 1 cycle while the key stays held → no pulse before reset; a single pulse 6 cycles after reset release.
- Auto-repeat (macro defined): hold KEY_N[0] for 30 cycles after acceptance → pulses at acceptance, acceptance+10, +13, +16, … until release; with the macro undefined, only the acceptance pulse.

Source files
------------

// File: rtl/key_debouncer.sv
// Two-flop synchroniser plus per-channel debounce FSM for four active-low keys and SW[0].
// Optional auto-repeat on held keys, enabled by defining KEY_DEBOUNCER_AUTO_REPEAT_EN.
module key_debouncer #(
    parameter int DB_CNT        = 1000000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000,
    parameter int CNT_W         = 25
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [3:0] KEY_N,
    input  logic       SW_RAW,
    output logic [3:0] KEY_LEVEL,
    output logic [3:0] KEY_PULSE,
    output logic       SW_OUT
);
    localparam int NCH = 5;
    // The counter tracks samples after the first one, so acceptance fires one short of DB_CNT-1.
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CNT - 2);
    localparam logic [NCH-1:0] SYNC_IDLE = 5'b01111;

    typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} db_state_t;

    logic [NCH-1:0] sync1, sync2, sample, level;

    // NOTE: synchroniser flops reset to the released raw value so no phantom edge follows reset.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            sync1 <= SYNC_IDLE;
            sync2 <= SYNC_IDLE;
        end else begin
            sync1 <= {SW_RAW, KEY_N};
            sync2 <= sync1;
        end
    end

    assign sample = {sync2[4], ~sync2[3:0]};

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        db_state_t        state, state_nx;
        logic [CNT_W-1:0] cnt, cnt_nx;
        logic             lvl_q;
        logic             s;

        assign s = sample[i];

        // NOTE: every output of this block gets a default first, so no latch can be inferred.
        always_comb begin
            state_nx = state;
            cnt_nx   = cnt;
            case (state)
                STABLE_LO: if (s) begin
                    state_nx = WAIT_HI;
                    cnt_nx   = '0;
                end
                WAIT_HI: begin
                    if (!s) begin
                        state_nx = STABLE_LO;
                        cnt_nx   = '0;
                    end else if (cnt >= DB_LAST) begin
                        state_nx = STABLE_HI;
                        cnt_nx   = '0;
                    end else if (cnt != '1) begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                STABLE_HI: if (!s) begin
                    state_nx = WAIT_LO;
                    cnt_nx   = '0;
                end
                WAIT_LO: begin
                    if (s) begin
                        state_nx = STABLE_HI;
                        cnt_nx   = '0;
                    end else if (cnt >= DB_LAST) begin
                        state_nx = STABLE_LO;
                        cnt_nx   = '0;
                    end else if (cnt != '1) begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nx = STABLE_LO;
                    cnt_nx   = '0;
                end
            endcase
        end

        // NOTE: sequential state uses non-blocking assignments only.
        always_ff @(posedge CLOCK_50) begin
            if (!RESET_N) begin
                state <= STABLE_LO;
                cnt   <= '0;
                lvl_q <= 1'b0;
            end else begin
                state <= state_nx;
                cnt   <= cnt_nx;
                lvl_q <= (state_nx == STABLE_HI) || (state_nx == WAIT_LO);
            end
        end

        assign level[i] = lvl_q;

        if (i < 4) begin : g_pulse
            logic pulse_q;
            logic fire;
`ifdef KEY_DEBOUNCER_AUTO_REPEAT_EN
            localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
            localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
            logic [CNT_W-1:0] rcnt, rcnt_nx;
            logic             rfirst, rfirst_nx;

            // Repeat count advances only while settled in STABLE_HI; WAIT_LO holds it.
            always_comb begin
                rcnt_nx   = rcnt;
                rfirst_nx = rfirst;
                fire      = 1'b0;
                if (state == STABLE_HI && state_nx == STABLE_HI) begin
                    if (rcnt >= (rfirst ? DELAY_LAST : PERIOD_LAST)) begin
                        fire      = 1'b1;
                        rcnt_nx   = '0;
                        rfirst_nx = 1'b0;
                    end else begin
                        rcnt_nx = rcnt + 1'b1;
                    end
                end else if (state_nx == STABLE_LO ||
                             (state == WAIT_HI && state_nx == STABLE_HI)) begin
                    rcnt_nx   = '0;
                    rfirst_nx = 1'b1;
                end
            end

            always_ff @(posedge CLOCK_50) begin
                if (!RESET_N) begin
                    rcnt   <= '0;
                    rfirst <= 1'b1;
                end else begin
                    rcnt   <= rcnt_nx;
                    rfirst <= rfirst_nx;
                end
            end
`else
            assign fire = 1'b0;
`endif
            always_ff @(posedge CLOCK_50) begin
                if (!RESET_N) pulse_q <= 1'b0;
                else          pulse_q <= (state == WAIT_HI && state_nx == STABLE_HI) || fire;
            end

            assign KEY_PULSE[i] = pulse_q;
        end
    end

    assign KEY_LEVEL = level[3:0];
    assign SW_OUT    = level[4];
endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer: directed test-plan steps plus random stimulus,
// every cycle compared against a run-length / hold-time reference model.
module tb_key_debouncer;
    localparam int DB_CNT        = 4;
    localparam int REPEAT_DELAY  = 10;
    localparam int REPEAT_PERIOD = 3;
    localparam int CNT_W         = 8;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N  = 1'b0;
    logic [3:0] KEY_N    = 4'hF;
    logic       SW_RAW   = 1'b0;
    logic [3:0] KEY_LEVEL;
    logic [3:0] KEY_PULSE;
    logic       SW_OUT;

    key_debouncer #(
        .DB_CNT       (DB_CNT),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD),
        .CNT_W        (CNT_W)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .KEY_N    (KEY_N),
        .SW_RAW   (SW_RAW),
        .KEY_LEVEL(KEY_LEVEL),
        .KEY_PULSE(KEY_PULSE),
        .SW_OUT   (SW_OUT)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int tests = 0;
    int fails = 0;
    int npulse [4];

    // Reference model: synchroniser delay, run length of samples disagreeing with the
    // accepted level, and number of settled held cycles for auto-repeat.
    bit         m_q1   [5];
    bit         m_q2   [5];
    bit         m_lvl  [5];
    bit         m_prev [5];
    int         m_run  [5];
    int         m_hold [5];
    logic [3:0] exp_level = 4'h0;
    logic [3:0] exp_pulse = 4'h0;
    logic       exp_sw    = 1'b0;

`ifdef KEY_DEBOUNCER_AUTO_REPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_n(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit raw, s, fire;
        for (int c = 0; c < 5; c++) begin
            if (!RESET_N) begin
                m_q1[c] = 0; m_q2[c] = 0; m_lvl[c] = 0; m_prev[c] = 0;
                m_run[c] = 0; m_hold[c] = 0;
                fire = 0;
            end else begin
                raw = (c < 4) ? ~KEY_N[c] : SW_RAW;
                s = m_q2[c];
                m_q2[c] = m_q1[c];
                m_q1[c] = raw;
                fire = 0;
                if (REPEAT_ON && m_lvl[c] && m_prev[c] && s) begin
                    m_hold[c]++;
                    if (m_hold[c] >= REPEAT_DELAY &&
                        (m_hold[c] - REPEAT_DELAY) % REPEAT_PERIOD == 0)
                        fire = 1;
                end
                m_run[c] = (s != m_lvl[c]) ? m_run[c] + 1 : 0;
                if (m_run[c] == DB_CNT) begin
                    m_lvl[c] = ~m_lvl[c];
                    m_run[c] = 0;
                    m_hold[c] = 0;
                    if (m_lvl[c]) fire = 1;
                end
                m_prev[c] = s;
            end
            if (c < 4) begin
                exp_level[c] = m_lvl[c];
                exp_pulse[c] = fire;
            end else begin
                exp_sw = m_lvl[c];
            end
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        model_edge();
        #1;
        check("level", KEY_LEVEL, exp_level);
        check("pulse", KEY_PULSE, exp_pulse);
        check("sw", {3'b000, SW_OUT}, {3'b000, exp_sw});
        for (int c = 0; c < 4; c++) npulse[c] += int'(KEY_PULSE[c]);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_counts();
        for (int c = 0; c < 4; c++) npulse[c] = 0;
    endtask

    initial begin
        clear_counts();

        // Reset with all keys held, then release reset.
        RESET_N = 1'b0; KEY_N = 4'b0000;
        run(5);
        check("rst_level", KEY_LEVEL, 4'h0);
        check("rst_pulse", KEY_PULSE, 4'h0);
        RESET_N = 1'b1;
        run(5);
        check("rst_early", KEY_PULSE, 4'h0);
        tick();
        check("rst_accept_pulse", KEY_PULSE, 4'hF);
        check("rst_accept_level", KEY_LEVEL, 4'hF);
        tick();
        check("rst_pulse_width", KEY_PULSE, 4'h0);
        KEY_N = 4'hF;
        run(8);
        check("all_released", KEY_LEVEL, 4'h0);

        // Clean press and release on key 2.
        KEY_N[2] = 1'b0;
        run(5);
        check("press_early", KEY_PULSE, 4'h0);
        tick();
        check("press_pulse", KEY_PULSE, 4'b0100);
        run(10);
        check("press_held", KEY_LEVEL, 4'b0100);
        KEY_N[2] = 1'b1;
        clear_counts();
        run(5);
        check("release_early", KEY_LEVEL, 4'b0100);
        tick();
        check("release_level", KEY_LEVEL, 4'b0000);
        run(4);
        check_n("release_nopulse", npulse[2], 0);

        // Bounce on key 0, every 2 cycles for 20 cycles.
        clear_counts();
        for (int i = 0; i < 10; i++) begin
            KEY_N[0] = (i % 2 == 1);
            run(2);
            check("bounce_level", KEY_LEVEL, 4'h0);
        end
        KEY_N[0] = 1'b1;
        run(8);
        check_n("bounce_nopulse", npulse[0], 0);

        // Simultaneous keys 1 and 3 with the switch.
        KEY_N[1] = 1'b0; KEY_N[3] = 1'b0; SW_RAW = 1'b1;
        run(5);
        tick();
        check("simul_pulse", KEY_PULSE, 4'b1010);
        check("simul_sw", {3'b000, SW_OUT}, 4'b0001);
        KEY_N = 4'hF; SW_RAW = 1'b0;
        run(8);

        // Reset during debounce of key 1.
        clear_counts();
        KEY_N[1] = 1'b0;
        run(3);
        RESET_N = 1'b0;
        tick();
        check_n("mid_rst_nopulse", npulse[1], 0);
        RESET_N = 1'b1;
        run(5);
        check("mid_rst_early", KEY_PULSE, 4'h0);
        tick();
        check("mid_rst_pulse", KEY_PULSE, 4'b0010);
        KEY_N[1] = 1'b1;
        run(8);

        // Long hold on key 0: acceptance plus repeats at +10, +13, ... when enabled.
        clear_counts();
        KEY_N[0] = 1'b0;
        run(6);
        check("hold_accept", KEY_PULSE, 4'b0001);
        run(30);
        check_n("hold_pulses", npulse[0], REPEAT_ON ? 8 : 1);
        KEY_N[0] = 1'b1;
        run(8);

        // Random stimulus: fast chatter first, then slow changes with long holds.
        for (int n = 0; n < 800; n++) begin
            int rate;
            rate = (n < 400) ? 7 : 40;
            RESET_N = ($urandom_range(0, 249) != 0);
            for (int c = 0; c < 4; c++)
                if ($urandom_range(0, rate) == 0) KEY_N[c] = ~KEY_N[c];
            if ($urandom_range(0, 11) == 0) SW_RAW = ~SW_RAW;
            tick();
        end
        RESET_N = 1'b1;
        run(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
